// File: rtl/fifo_level.sv
// Single-clock show-ahead FIFO with arbitrary depth, live fill level,
// programmable almost-full/almost-empty thresholds, flush and sticky error flags.
module fifo_level #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       push,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    logic [LW-1:0]         w_level_next;

    // Explicit wrap so non-power-of-two depths never rely on binary rollover.
    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full    = (r_level == LW'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_rd_acc  = pop & ~w_empty;
    assign w_wr_acc  = push & (~w_full | pop);
    assign w_ovf_set = ~flush & push & w_full & ~pop;
    assign w_unf_set = ~flush & pop & w_empty;

    always_comb begin
        w_level_next = r_level;
        if (w_wr_acc && !w_rd_acc) begin
            w_level_next = r_level + LW'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_level_next = r_level - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_wr_acc) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
                if (w_rd_acc) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
                r_level <= w_level_next;
            end
            // A same-cycle error event wins over the software clear.
            r_overflow  <= w_ovf_set | (r_overflow  & ~clr_err);
            r_underflow <= w_unf_set | (r_underflow & ~clr_err);
        end
    end

    // Storage is deliberately unreset; when full with push+pop, wr_ptr == rd_ptr
    // and the old word is still read combinationally this cycle.
    always_ff @(posedge clk) begin
        if (!flush && w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout         = r_mem[r_rd_ptr];
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_level >= LW'(AF_LEVEL));
    assign almost_empty = (r_level <= LW'(AE_LEVEL));
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_level.sv
// Directed self-checking bench for fifo_level at DEPTH=6, AF_LEVEL=4, AE_LEVEL=1.
module tb_fifo_level;
    localparam int DW = 8;
    localparam int DEPTH = 6;

    logic          clk;
    logic          reset;
    logic          flush;
    logic [DW-1:0] din;
    logic          push;
    logic          pop;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [2:0]    level;
    logic          overflow;
    logic          underflow;
    logic          clr_err;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_level #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(4), .AE_LEVEL(1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .din(din), .push(push), .pop(pop),
        .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .level(level), .overflow(overflow),
        .underflow(underflow), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // One clock cycle with the given request inputs; returns 1 ns after the edge.
    task automatic step(input logic p, input logic q, input logic [DW-1:0] d,
                        input logic f, input logic c);
        push = p; pop = q; din = d; flush = f; clr_err = c;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    logic [DW-1:0] q_model[$];
    logic [DW-1:0] exp_d;
    logic [DW-1:0] nxt;

    initial begin
        reset = 1'b1; flush = 1'b0; din = '0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);

        // Reset asserted between edges mid-stream
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(i + 1), 1'b0, 1'b0);
        chk("pre_rst_level", 32'(level), 5);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_level", 32'(level), 0);
        chk("async_rst_empty", 32'(empty), 1);
        chk("async_rst_ae", 32'(almost_empty), 1);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        chk("post_rst_dout", 32'(dout), 32'hA5);
        chk("post_rst_level", 32'(level), 1);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("post_rst_drain", 32'(level), 0);

        // Fill to full, overflow, drain
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 1'b0);
            chk("fill_level", 32'(level), 32'(i + 1));
            chk("fill_af", 32'(almost_full), 32'((i + 1) >= 4));
            chk("fill_full", 32'(full), 32'((i + 1) == DEPTH));
            chk("fill_dout", 32'(dout), 32'h10);
        end
        chk("fill_ovf_before", 32'(overflow), 0);
        step(1'b1, 1'b0, 8'h16, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_level", 32'(level), 6);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_dout", 32'(dout), 32'(8'h10 + i));
            step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            chk("drain_level", 32'(level), 32'(5 - i));
            chk("drain_ae", 32'(almost_empty), 32'((5 - i) <= 1));
            chk("drain_empty", 32'(empty), 32'((5 - i) == 0));
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 0);
        chk("unf_none", 32'(underflow), 0);

        // Wrap-around with scoreboard: bursts of 4 pushes then 3 pops
        nxt = 8'h30;
        for (int c = 0; c < 20; c++) begin
            if ((c % 7) < 4) begin
                step(1'b1, 1'b0, nxt, 1'b0, 1'b0);
                if (q_model.size() < DEPTH) q_model.push_back(nxt);
                nxt = nxt + 8'd1;
            end else begin
                exp_d = q_model[0];
                chk("wrap_dout", 32'(dout), 32'(exp_d));
                step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
                void'(q_model.pop_front());
            end
            chk("wrap_level", 32'(level), 32'(q_model.size()));
        end
        while (q_model.size() > 0) begin
            exp_d = q_model[0];
            chk("wrap_tail_dout", 32'(dout), 32'(exp_d));
            step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            void'(q_model.pop_front());
        end
        chk("wrap_empty", 32'(empty), 1);
        chk("wrap_ovf", 32'(overflow), 0);

        // Push+pop while full
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b0);
        chk("pp_full", 32'(full), 1);
        chk("pp_dout_before", 32'(dout), 32'h20);
        step(1'b1, 1'b1, 8'h26, 1'b0, 1'b0);
        chk("pp_dout_after", 32'(dout), 32'h21);
        chk("pp_level", 32'(level), 6);
        chk("pp_ovf", 32'(overflow), 0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("pp_drain", 32'(dout), 32'(8'h21 + i));
            step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        end
        chk("pp_drained", 32'(empty), 1);

        // Push+pop while empty, then error-clear interplay
        step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        chk("pe_level", 32'(level), 1);
        chk("pe_dout", 32'(dout), 32'h77);
        chk("pe_unf", 32'(underflow), 1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_unf", 32'(underflow), 0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("pe_pop_ok", 32'(underflow), 0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        chk("set_beats_clr", 32'(underflow), 1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_unf2", 32'(underflow), 0);

        // Flush with push and pop asserted
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h46, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("fl_pre_level", 32'(level), 3);
        chk("fl_pre_ovf", 32'(overflow), 1);
        step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
        chk("fl_level", 32'(level), 0);
        chk("fl_empty", 32'(empty), 1);
        chk("fl_ovf_kept", 32'(overflow), 1);
        chk("fl_unf", 32'(underflow), 0);
        step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        chk("fl_push_dout", 32'(dout), 32'h5A);
        chk("fl_push_level", 32'(level), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
